ps_mailbox_responder: RTL and testbench

PL-side endpoint of the PS↔PL serial mailbox exported by the system wrapper. It captures 192-bit command frames written by the PS on `sys_outputs_serial` when the PS rings a doorbell on `sys_intr_output`, and hands each frame to user logic over a valid/ready handshake. It returns a 96-bit result frame on `sys_inputs_serial` and raises PS interrupts on `sys_intr_input`, holding each one until the PS acknowledges it on `sys_intr_ack`.

---
 rtl/ps_mailbox_pkg.sv | 72 +++++++
 rtl/ps_mailbox_responder_sync_edge.sv | 32 +++
 rtl/ps_mailbox_responder.sv | 186 ++++++++++++++++++
 tb/tb_ps_mailbox_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps_mailbox_pkg.sv
// ps_mailbox_pkg: shared types, widths and bit positions for the PS<->PL
// serial mailbox responder (command frame, result frame, status word,
// interrupt/event indices and the responder FSM state encoding).
package ps_mailbox_pkg;

  // Frame widths
  localparam int unsigned CMD_W   = 192;
  localparam int unsigned RES_W   = 96;
  localparam int unsigned RSP_W   = 64;
  localparam int unsigned SEQ_W   = 16;
  localparam int unsigned TAG_W   = 8;

  // Command header fields (word0 of the command frame)
  localparam int unsigned HDR_TAG_LSB = 0;
  localparam int unsigned HDR_OP_LSB  = 8;
  localparam int unsigned HDR_OP_W    = 8;

  // Status word bit positions (status occupies result frame [95:64])
  localparam int unsigned ST_TAG_LSB   = 0;
  localparam int unsigned ST_OVR_BIT   = 8;
  localparam int unsigned ST_TO_BIT    = 9;
  localparam int unsigned ST_STATE_LSB = 12;
  localparam int unsigned ST_SEQ_LSB   = 16;

  // PS event inputs (sys_intr_output) and acknowledges (sys_intr_ack)
  localparam int unsigned EV_DOORBELL = 0;
  localparam int unsigned EV_ABORT    = 1;
  localparam int unsigned ACK_DONE    = 0;
  localparam int unsigned ACK_ERR     = 1;

  // PS interrupt outputs (sys_intr_input)
  localparam int unsigned IRQ_DONE = 0;
  localparam int unsigned IRQ_ERR  = 1;
  localparam int unsigned IRQ_BUSY = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } mbx_state_e;

  // Status word layout, MSB first
  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [1:0]       rsvd_hi;
    logic [1:0]       state;
    logic [1:0]       rsvd_lo;
    logic             timeout;
    logic             overrun;
    logic [TAG_W-1:0] tag;
  } mbx_status_t;

  function automatic mbx_status_t pack_status(
    input logic [SEQ_W-1:0] seq,
    input mbx_state_e       state,
    input logic             timeout,
    input logic             overrun,
    input logic [TAG_W-1:0] tag
  );
    mbx_status_t s;
    s.seq     = seq;
    s.rsvd_hi = 2'b00;
    s.state   = 2'(state);
    s.rsvd_lo = 2'b00;
    s.timeout = timeout;
    s.overrun = overrun;
    s.tag     = tag;
    return s;
  endfunction

endpackage

// File: rtl/ps_mailbox_responder_sync_edge.sv
// sync_edge: WIDTH-bit multi-flop synchronizer (DEPTH >= 2 stages) followed
// by a registered rising-edge detector producing one-cycle pulses.
// Ports: clk, rst_n (async active-low), d (async level inputs),
//        rise (one-cycle pulse per rising edge of d, DEPTH+1 cycles later).
module sync_edge #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] sync_q [DEPTH];
  logic [WIDTH-1:0] prev_q;

  // Synchronizer chain, previous-value flop and registered edge pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) sync_q[i] <= '0;
      prev_q <= '0;
      rise   <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[DEPTH-1];
      rise   <= sync_q[DEPTH-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/ps_mailbox_responder.sv
// ps_mailbox_responder: PL endpoint of the PS<->PL serial mailbox.
// Captures a 192-bit command frame on the PS doorbell, hands it to user logic
// (cmd_valid/cmd_ready), collects a 64-bit response (rsp_valid/rsp_ready),
// publishes {status, response} on sys_inputs_serial and raises done/error/busy
// interrupts until the PS acknowledges.
// Ports:
//   sys_clk0, sys_resetn        clock, async active-low reset
//   sys_outputs_serial[191:0]   PS command frame (sampled on doorbell)
//   sys_intr_output[5:0]        PS events: [0] doorbell, [1] abort
//   sys_intr_ack[4:0]           PS acks: [0] done, [1] error
//   sys_inputs_serial[95:0]     result frame: [95:64] status, [63:0] data
//   sys_intr_input[2:0]         interrupts: [0] done, [1] error, [2] busy
//   cmd_valid/cmd_ready/cmd_data  command handshake to user logic
//   rsp_valid/rsp_ready/rsp_data  response handshake from user logic
// Build option: define MBX_ACK_TIMEOUT_EN to abandon RESP after
// TIMEOUT_CYCLES cycles without a done acknowledge (sets the timeout flag).
// SYNC_STAGES must be >= 2.
module ps_mailbox_responder
  import ps_mailbox_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              sys_clk0,
  input  logic              sys_resetn,
  input  logic [CMD_W-1:0]  sys_outputs_serial,
  input  logic [5:0]        sys_intr_output,
  input  logic [4:0]        sys_intr_ack,
  output logic [RES_W-1:0]  sys_inputs_serial,
  output logic [2:0]        sys_intr_input,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [CMD_W-1:0]  cmd_data,
  input  logic              rsp_valid,
  output logic              rsp_ready,
  input  logic [RSP_W-1:0]  rsp_data
);

  logic [1:0] ps_ev;
  logic [1:0] ack_ev;

  mbx_state_e       state_q, state_d;
  logic             cmd_valid_d;
  logic [CMD_W-1:0] cmd_data_d;
  logic             done_d;
  logic             ovr_q, ovr_d;
  logic             to_q, to_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [RSP_W-1:0] rsp_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             seq_inc;
  logic             to_hit;
  mbx_status_t      status_d;
  logic             unused_ok;

  sync_edge #(.WIDTH(2), .DEPTH(SYNC_STAGES)) u_ev_sync (
    .clk   (sys_clk0),
    .rst_n (sys_resetn),
    .d     (sys_intr_output[1:0]),
    .rise  (ps_ev)
  );

  sync_edge #(.WIDTH(2), .DEPTH(SYNC_STAGES)) u_ack_sync (
    .clk   (sys_clk0),
    .rst_n (sys_resetn),
    .d     (sys_intr_ack[1:0]),
    .rise  (ack_ev)
  );

  assign rsp_ready = (state_q == ST_EXEC);

`ifdef MBX_ACK_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] to_cnt_q;

  // Cycles spent in RESP; cleared whenever RESP is left
  always_ff @(posedge sys_clk0 or negedge sys_resetn) begin
    if (!sys_resetn)                                   to_cnt_q <= '0;
    else if (state_q == ST_RESP && state_d == ST_RESP) to_cnt_q <= to_cnt_q + TO_W'(1);
    else                                               to_cnt_q <= '0;
  end

  assign to_hit    = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign unused_ok = ^{sys_intr_output[5:2], sys_intr_ack[4:2]};
`else
  assign to_hit    = 1'b0;
  assign unused_ok = ^{sys_intr_output[5:2], sys_intr_ack[4:2], 32'(TIMEOUT_CYCLES)};
`endif

  assign seq_d = seq_inc ? seq_q + SEQ_W'(1) : seq_q;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid;
    cmd_data_d  = cmd_data;
    done_d      = sys_intr_input[IRQ_DONE];
    ovr_d       = ovr_q;
    to_d        = to_q;
    tag_d       = tag_q;
    rsp_d       = sys_inputs_serial[RSP_W-1:0];
    seq_inc     = 1'b0;

    // Error clear first so a same-cycle flag set overrides it
    if (ack_ev[ACK_ERR]) begin
      ovr_d = 1'b0;
      to_d  = 1'b0;
    end

    if (ps_ev[EV_ABORT]) begin
      // Abort swallows a coincident doorbell without flagging overrun
      state_d     = ST_IDLE;
      cmd_valid_d = 1'b0;
      done_d      = 1'b0;
    end else begin
      if (ps_ev[EV_DOORBELL] && state_q != ST_IDLE) ovr_d = 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (ps_ev[EV_DOORBELL]) begin
            cmd_data_d  = sys_outputs_serial;
            cmd_valid_d = 1'b1;
            state_d     = ST_CMD;
          end
        end
        ST_CMD: begin
          if (cmd_valid && cmd_ready) begin
            cmd_valid_d = 1'b0;
            state_d     = ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (rsp_valid) begin
            rsp_d   = rsp_data;
            tag_d   = cmd_data[HDR_TAG_LSB +: TAG_W];
            seq_inc = 1'b1;
            done_d  = 1'b1;
            state_d = ST_RESP;
          end
        end
        ST_RESP: begin
          if (ack_ev[ACK_DONE]) begin
            done_d  = 1'b0;
            state_d = ST_IDLE;
          end else if (to_hit) begin
            to_d    = 1'b1;
            done_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    status_d = pack_status(seq_d, state_d, to_d, ovr_d, tag_d);
  end

  // State, flags and registered outputs; status refreshed every cycle
  always_ff @(posedge sys_clk0 or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state_q           <= ST_IDLE;
      cmd_valid         <= 1'b0;
      cmd_data          <= '0;
      ovr_q             <= 1'b0;
      to_q              <= 1'b0;
      tag_q             <= '0;
      sys_inputs_serial <= '0;
      sys_intr_input    <= '0;
    end else begin
      state_q           <= state_d;
      cmd_valid         <= cmd_valid_d;
      cmd_data          <= cmd_data_d;
      ovr_q             <= ovr_d;
      to_q              <= to_d;
      tag_q             <= tag_d;
      sys_inputs_serial <= {status_d, rsp_d};
      sys_intr_input    <= {(state_d != ST_IDLE), (ovr_d | to_d), done_d};
    end
  end

  // Response sequence counter, advances only on an accepted response
  always_ff @(posedge sys_clk0 or negedge sys_resetn) begin
    if (!sys_resetn)  seq_q <= '0;
    else if (seq_inc) seq_q <= seq_d;
  end

endmodule

// File: tb/tb_ps_mailbox_responder.sv
// Directed bench for ps_mailbox_responder: basic transaction with exact
// doorbell/response/ack latencies, overrun, abort+doorbell, sequence wrap,
// reset in EXEC and (when MBX_ACK_TIMEOUT_EN is defined) ack timeout.
module tb_ps_mailbox_responder;

  logic          sys_clk0 = 1'b0;
  logic          sys_resetn;
  logic [191:0]  sys_outputs_serial;
  logic [5:0]    sys_intr_output;
  logic [4:0]    sys_intr_ack;
  logic [95:0]   sys_inputs_serial;
  logic [2:0]    sys_intr_input;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [191:0]  cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [63:0]   rsp_data;

  int checks = 0;
  int errors = 0;

  ps_mailbox_responder #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
    .sys_clk0           (sys_clk0),
    .sys_resetn         (sys_resetn),
    .sys_outputs_serial (sys_outputs_serial),
    .sys_intr_output    (sys_intr_output),
    .sys_intr_ack       (sys_intr_ack),
    .sys_inputs_serial  (sys_inputs_serial),
    .sys_intr_input     (sys_intr_input),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_data           (cmd_data),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_data           (rsp_data)
  );

  always #5 sys_clk0 = ~sys_clk0;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ring(input logic [191:0] frame);
    sys_outputs_serial = frame;
    sys_intr_output[0] = 1'b1;
    @(negedge sys_clk0);
    sys_intr_output[0] = 1'b0;
  endtask

  task automatic pulse_ack(input int b);
    sys_intr_ack[b] = 1'b1;
    @(negedge sys_clk0);
    sys_intr_ack[b] = 1'b0;
  endtask

  task automatic start_cmd(input string tag, input logic [191:0] frame);
    int n = 0;
    ring(frame);
    while (cmd_valid !== 1'b1 && n < 20) begin @(negedge sys_clk0); n++; end
    check({tag, "_cmd_valid"}, 192'(cmd_valid), 192'(1));
    check({tag, "_cmd_data"}, cmd_data, frame);
  endtask

  task automatic give_rsp(input string tag, input logic [63:0] d);
    int n = 0;
    while (rsp_ready !== 1'b1 && n < 20) begin @(negedge sys_clk0); n++; end
    check({tag, "_rsp_ready"}, 192'(rsp_ready), 192'(1));
    rsp_valid = 1'b1;
    rsp_data  = d;
    @(negedge sys_clk0);
    rsp_valid = 1'b0;
  endtask

  task automatic finish_ack(input string tag);
    int n = 0;
    pulse_ack(0);
    while (sys_intr_input[0] !== 1'b0 && n < 20) begin @(negedge sys_clk0); n++; end
    check({tag, "_done_clear"}, 192'(sys_intr_input), 192'(3'b000));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [191:0] f1, f2, f3, f4, f6;
    f1 = {32'h5555_0005, 32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_075A};
    f2 = {160'hA5A5_0000_1111_2222_3333_4444_5555_6666_7777_8888, 32'h0000_0233};
    f3 = {160'h0, 32'h0000_0977};
    f4 = {160'h1, 32'h0000_0111};
    f6 = {160'h2, 32'h0000_0366};

    sys_resetn = 1'b0;
    sys_outputs_serial = '0;
    sys_intr_output = '0;
    sys_intr_ack = '0;
    cmd_ready = 1'b1;
    rsp_valid = 1'b0;
    rsp_data = '0;
    repeat (3) @(negedge sys_clk0);
    check("rst_cmd_valid", 192'(cmd_valid), 192'(0));
    check("rst_cmd_data", cmd_data, 192'(0));
    check("rst_rsp_ready", 192'(rsp_ready), 192'(0));
    check("rst_result", 192'(sys_inputs_serial), 192'(0));
    check("rst_irq", 192'(sys_intr_input), 192'(0));
    sys_resetn = 1'b1;
    @(negedge sys_clk0);

    // Basic transaction with exact latencies
    ring(f1);
    repeat (2) @(negedge sys_clk0);
    check("t1_cmd_valid_early", 192'(cmd_valid), 192'(0));
    @(negedge sys_clk0);
    check("t1_cmd_valid_n3", 192'(cmd_valid), 192'(1));
    check("t1_cmd_data", cmd_data, f1);
    check("t1_irq_busy", 192'(sys_intr_input), 192'(3'b100));
    check("t1_status_cmd", 192'(sys_inputs_serial[95:64]), 192'(32'h0000_1000));
    @(negedge sys_clk0);
    check("t1_exec_cmd_valid", 192'(cmd_valid), 192'(0));
    check("t1_exec_rsp_ready", 192'(rsp_ready), 192'(1));
    check("t1_status_exec", 192'(sys_inputs_serial[95:64]), 192'(32'h0000_2000));
    rsp_valid = 1'b1;
    rsp_data  = 64'h0123_4567_89AB_CDEF;
    @(negedge sys_clk0);
    rsp_valid = 1'b0;
    check("t1_result", 192'(sys_inputs_serial), 192'({32'h0001_305A, 64'h0123_4567_89AB_CDEF}));
    check("t1_irq_done", 192'(sys_intr_input), 192'(3'b101));
    check("t1_rsp_ready_low", 192'(rsp_ready), 192'(0));
    pulse_ack(0);
    repeat (2) @(negedge sys_clk0);
    check("t1_done_held", 192'(sys_intr_input), 192'(3'b101));
    @(negedge sys_clk0);
    check("t1_done_clear", 192'(sys_intr_input), 192'(3'b000));
    check("t1_status_idle", 192'(sys_inputs_serial[95:64]), 192'(32'h0001_005A));

    // Overrun: second doorbell while in EXEC
    start_cmd("t2", f2);
    @(negedge sys_clk0);
    check("t2_exec", 192'(rsp_ready), 192'(1));
    ring(f4);
    repeat (3) @(negedge sys_clk0);
    check("t2_irq_err", 192'(sys_intr_input), 192'(3'b110));
    check("t2_status_ovr", 192'(sys_inputs_serial[95:64]), 192'(32'h0001_215A));
    check("t2_cmd_data_kept", cmd_data, f2);
    give_rsp("t2", 64'hDEAD_BEEF_0000_0002);
    check("t2_result", 192'(sys_inputs_serial), 192'({32'h0002_3133, 64'hDEAD_BEEF_0000_0002}));
    check("t2_irq_resp", 192'(sys_intr_input), 192'(3'b111));
    pulse_ack(0);
    repeat (3) @(negedge sys_clk0);
    check("t2_irq_after_ack0", 192'(sys_intr_input), 192'(3'b010));
    check("t2_status_after_ack0", 192'(sys_inputs_serial[95:64]), 192'(32'h0002_0133));
    pulse_ack(1);
    repeat (3) @(negedge sys_clk0);
    check("t2_irq_after_ack1", 192'(sys_intr_input), 192'(3'b000));
    check("t2_status_after_ack1", 192'(sys_inputs_serial[95:64]), 192'(32'h0002_0033));

    // Abort coincident with a doorbell while in CMD
    cmd_ready = 1'b0;
    start_cmd("t3", f3);
    @(negedge sys_clk0);
    check("t3_cmd_valid_hold", 192'(cmd_valid), 192'(1));
    sys_intr_output[1:0] = 2'b11;
    @(negedge sys_clk0);
    sys_intr_output[1:0] = 2'b00;
    repeat (2) @(negedge sys_clk0);
    check("t3_cmd_valid_pre_abort", 192'(cmd_valid), 192'(1));
    @(negedge sys_clk0);
    check("t3_cmd_valid_drop", 192'(cmd_valid), 192'(0));
    check("t3_irq", 192'(sys_intr_input), 192'(3'b000));
    check("t3_result_kept", 192'(sys_inputs_serial), 192'({32'h0002_0033, 64'hDEAD_BEEF_0000_0002}));
    cmd_ready = 1'b1;

    // Sequence counter wrap from 0xFFFF
    force dut.seq_q = 16'hFFFF;
    @(negedge sys_clk0);
    release dut.seq_q;
    start_cmd("t4", f4);
    give_rsp("t4", 64'h0000_0000_0000_0004);
    check("t4_status_wrap", 192'(sys_inputs_serial[95:64]), 192'(32'h0000_3011));
    finish_ack("t4");

    // Reset in EXEC, then a fresh transaction
    start_cmd("t6", f2);
    @(negedge sys_clk0);
    check("t6_exec", 192'(rsp_ready), 192'(1));
    #2 sys_resetn = 1'b0;
    #1;
    check("t6_rst_cmd_valid", 192'(cmd_valid), 192'(0));
    check("t6_rst_cmd_data", cmd_data, 192'(0));
    check("t6_rst_rsp_ready", 192'(rsp_ready), 192'(0));
    check("t6_rst_result", 192'(sys_inputs_serial), 192'(0));
    check("t6_rst_irq", 192'(sys_intr_input), 192'(0));
    @(negedge sys_clk0);
    sys_resetn = 1'b1;
    @(negedge sys_clk0);
    start_cmd("t6b", f6);
    give_rsp("t6b", 64'hFEED_0000_0000_0006);
    check("t6_result", 192'(sys_inputs_serial), 192'({32'h0001_3066, 64'hFEED_0000_0000_0006}));
    finish_ack("t6");

`ifdef MBX_ACK_TIMEOUT_EN
    // No ack in RESP: timeout after 16 cycles
    start_cmd("t5", f1);
    give_rsp("t5", 64'h5);
    repeat (15) @(negedge sys_clk0);
    check("t5_done_before", 192'(sys_intr_input), 192'(3'b101));
    @(negedge sys_clk0);
    check("t5_irq_timeout", 192'(sys_intr_input), 192'(3'b010));
    check("t5_status_to", 192'(sys_inputs_serial[73]), 192'(1));
    check("t5_state_idle", 192'(sys_inputs_serial[77:76]), 192'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
